// File: rtl/id_counter_dco.sv
// Increment/decrement counter and divide-by-N DCO for the all-digital PLL.
// Carry/borrow pulses insert or delete pulses in a clk/2 stream that is then divided by N_DIV.
module id_counter_dco #(
  parameter int unsigned N_DIV = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carry,
  input  logic             borrow,
  output logic             id_out,
  output logic [CNT_W-1:0] div_count,
  output logic             dco_out
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N_DIV / 2);

  typedef enum logic [1:0] {
    P_NONE   = 2'b00,
    P_CARRY  = 2'b01,
    P_BORROW = 2'b10
  } pend_t;

  logic             t_q, t_d;
  pend_t            pend_q, pend_d, pend_cons;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_en;
  logic             id_out_d, dco_out_d;

  assign div_count = cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q     <= 1'b0;
      pend_q  <= P_NONE;
      cnt_q   <= {CNT_W{1'b0}};
      id_out  <= 1'b0;
      dco_out <= 1'b0;
    end else begin
      t_q     <= t_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      id_out  <= id_out_d;
      dco_out <= dco_out_d;
    end
  end

  // Enable decode, pending-request update and divider next state
  always_comb begin
    t_d       = ~t_q;
    pend_cons = pend_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    id_en     = 1'b0;
    id_out_d  = 1'b0;
    dco_out_d = 1'b0;

    // t=1 slots are the nominal pulses; t=0 slots are free for insertion
    if (t_q) id_en = (pend_q != P_BORROW);
    else     id_en = (pend_q == P_CARRY);

    if (!t_q && pend_q == P_CARRY)  pend_cons = P_NONE;
    if (t_q  && pend_q == P_BORROW) pend_cons = P_NONE;

    pend_d = pend_cons;
    if (carry && !borrow)
      pend_d = (pend_cons == P_BORROW) ? P_NONE : P_CARRY;
    else if (borrow && !carry)
      pend_d = (pend_cons == P_CARRY) ? P_NONE : P_BORROW;

    if (id_en)
      cnt_d = (cnt_q == CNT_MAX) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);

    id_out_d  = id_en;
    dco_out_d = (cnt_d < CNT_HALF);
  end

endmodule

// File: tb/tb_id_counter_dco.sv
// Directed self-checking bench for id_counter_dco (N_DIV=8).
module tb_id_counter_dco;

  localparam int unsigned N_DIV = 8;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             carry;
  logic             borrow;
  logic             id_out;
  logic [CNT_W-1:0] div_count;
  logic             dco_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rises[$];
  logic dco_prev = 1'b0;

  id_counter_dco #(.N_DIV(N_DIV), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .carry    (carry),
    .borrow   (borrow),
    .id_out   (id_out),
    .div_count(div_count),
    .dco_out  (dco_out)
  );

  always #5 clk = ~clk;

  // Record the cycle index of every observed dco_out rising edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dco_out === 1'b1 && dco_prev === 1'b0) rises.push_back(cyc);
    dco_prev <= dco_out;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int n, input int limit, input string tag, output bit ok);
    int k;
    k = 0;
    while (rises.size() < n && k < limit) begin
      tick();
      k++;
    end
    ok = (rises.size() >= n);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, got %0d dco rises, required %0d", tag, rises.size(), n);
    end
  endtask

  // Walk the nominal sequence starting at the edge that releases reset
  task automatic release_sequence(input string tag, input int n_edges);
    int   exp_cnt;
    logic exp_id, exp_dco;
    reset = 1'b0;
    for (int n = 1; n <= n_edges; n++) begin
      tick();
      exp_cnt = (n / 2) % 8;
      exp_id  = (n % 2 == 0);
      exp_dco = (exp_cnt < 4);
      checks++;
      if (div_count !== CNT_W'(exp_cnt) || id_out !== exp_id || dco_out !== exp_dco) begin
        errors++;
        $display("FAIL %s edge %0d: cnt=%0d id=%b dco=%b, required cnt=%0d id=%b dco=%b",
                 tag, n, div_count, id_out, dco_out, exp_cnt, exp_id, exp_dco);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; carry = 1'b0; borrow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (id_out !== 1'b0 || dco_out !== 1'b0 || div_count !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold %0d: id=%b dco=%b cnt=%0d, required 0 0 0", i, id_out, dco_out, div_count);
      end
    end
    release_sequence("nominal_after_reset", 34);
  endtask

  task automatic test_nominal_period();
    bit ok;
    rises.delete();
    wait_rises(3, 80, "nominal_period_wait", ok);
    if (ok) begin
      checks++;
      if (rises[1] - rises[0] != 16 || rises[2] - rises[1] != 16) begin
        errors++;
        $display("FAIL nominal_period: %0d %0d, required 16 16", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
  endtask

  // One request pulse shortly after a rise; expect one deviated period then nominal
  task automatic test_request(input string tag, input logic c, input logic b, input int exp_first);
    bit ok;
    rises.delete();
    wait_rises(1, 40, {tag, "_sync"}, ok);
    if (!ok) return;
    repeat (5) tick();
    carry = c; borrow = b;
    tick();
    carry = 1'b0; borrow = 1'b0;
    wait_rises(4, 100, {tag, "_wait"}, ok);
    if (ok) begin
      checks++;
      if (rises[1] - rises[0] != exp_first) begin
        errors++;
        $display("FAIL %s_first: period %0d, required %0d", tag, rises[1] - rises[0], exp_first);
      end
      checks++;
      if (rises[2] - rises[1] != 16 || rises[3] - rises[2] != 16) begin
        errors++;
        $display("FAIL %s_after: periods %0d %0d, required 16 16", tag,
                 rises[2] - rises[1], rises[3] - rises[2]);
      end
    end
  endtask

  task automatic test_held_carry();
    int hi;
    bit ok;
    carry = 1'b1;
    repeat (4) tick();
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (id_out === 1'b1) hi++;
    end
    checks++;
    if (hi != 16) begin
      errors++;
      $display("FAIL held_carry_id: id_out high %0d of 16 clk, required 16", hi);
    end
    rises.delete();
    wait_rises(3, 30, "held_carry_wait", ok);
    if (ok) begin
      checks++;
      if (rises[1] - rises[0] != 8 || rises[2] - rises[1] != 8) begin
        errors++;
        $display("FAIL held_carry_period: %0d %0d, required 8 8", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    carry = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_held_borrow();
    int bad;
    logic [CNT_W-1:0] cnt0;
    logic dco0;
    borrow = 1'b1;
    repeat (4) tick();
    cnt0 = div_count;
    dco0 = dco_out;
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (id_out !== 1'b0 || div_count !== cnt0 || dco_out !== dco0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_borrow: %0d cycles with activity, required 0", bad);
    end
    borrow = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (div_count !== 3'd5 && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (div_count !== 3'd5) begin
      errors++;
      $display("FAIL reset_mid_sync: div_count=%0d, required 5", div_count);
    end
    carry = 1'b1;
    tick();
    carry = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (div_count !== 3'd0 || dco_out !== 1'b0 || id_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d dco=%b id=%b, required 0 0 0", div_count, dco_out, id_out);
    end
    tick();
    release_sequence("after_mid_reset", 24);
  endtask

  initial begin
    reset = 1'b1; carry = 1'b0; borrow = 1'b0;
    test_reset();
    test_nominal_period();
    test_request("single_carry", 1'b1, 1'b0, 14);
    test_request("single_borrow", 1'b0, 1'b1, 18);
    test_request("carry_and_borrow", 1'b1, 1'b1, 16);
    test_held_carry();
    test_nominal_period();
    test_held_borrow();
    test_nominal_period();
    test_reset_mid();
    test_nominal_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_counter_dco.md
# id_counter_dco

Increment/decrement (ID) counter and divide-by-N digital-controlled oscillator (DCO) for the all-digital PLL. It sits directly downstream of the K-counter loop filter. It consumes the filter's `carry` and `borrow` pulses, inserts or deletes pulses in a clk/2 pulse stream, and divides that stream down to produce `dco_out`. `dco_out` is the feedback signal returned to the XOR phase detector.

## Interface
- `N_DIV`, default 8: divider modulus. Must be even and at least 2.
- `CNT_W`, default 3: divider counter width. Must satisfy 2^CNT_W >= N_DIV.

- `clk`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `carry`  in  1  one-cycle pulse from the loop filter; requests one inserted ID pulse (phase advance)
- `borrow`  in  1  one-cycle pulse from the loop filter; requests one deleted ID pulse (phase retard)
- `id_out`  out  1  registered ID pulse stream (one clk-wide pulse per divider advance)
- `div_count`  out  CNT_W  current divider count, 0..N_DIV-1
- `dco_out`  out  1  DCO output, feedback to the phase detector

## Operation
- **State registers**
  - `t`: toggle, 1 bit.
  - `P`: pending request, with values +1 (carry pending), 0, or -1 (borrow pending).
  - `cnt`: divider count, CNT_W bits.
  - `id_out` and `dco_out`: registered outputs.
- **Enable.** `id_en` is decoded from registered state only:
  - When t=1, id_en = (P != -1). A pending borrow deletes this pulse.
  - When t=0, id_en = (P == +1). A pending carry inserts a pulse here.
- **Per edge, when `reset` = 0:**
  - t <= ~t.
  - **Consume.** If t=0 and P=+1, P becomes 0. If t=1 and P=-1, P becomes 0.
  - **Apply request.** net = +1 if carry&~borrow, -1 if borrow&~carry, 0 otherwise. P <= clamp(P_after_consume + net, -1, +1).
  - Carry and borrow in the same cycle cancel.
  - A request beyond saturation is dropped.
  - A carry arriving while a borrow is pending cancels the borrow, and vice versa.
  - **Divider.** If id_en, cnt <= (cnt == N_DIV-1) ? 0 : cnt+1. Otherwise cnt holds.
  - **Outputs.** id_out <= id_en; dco_out <= (cnt_next < N_DIV/2), where cnt_next is the value cnt takes on this edge. div_count = cnt.
- **Frequency range**
  - Nominal: one ID pulse per 2 clk. DCO period is 2*N_DIV clk, 50% duty.
  - carry held high: one ID pulse every clk, period N_DIV. This is the maximum.
  - borrow held high: no ID pulses, `dco_out` frozen. This is the minimum.
- **Reset**
  - Synchronous; overrides everything, including mid-cycle activity and pending requests.
  - t=0, P=0, cnt=0, id_out=0, dco_out=0.
  - On the first edge after release: t=0 so id_en=0, cnt stays 0, and dco_out becomes 1.

## Timing
- Request latency, from P=0:
  - A carry sampled at edge k sets P at k.
  - The pulse is inserted at the first later edge where t=0: edge k+1 or k+2.
  - Borrow deletion occurs at the first later edge where t=1: edge k+1 or k+2.
- `id_out` lags `id_en` by one edge. `dco_out` reflects the count updated on the same edge.
- Each insertion shortens the current DCO period by 2 clk. Each deletion lengthens it by 2 clk.
- Divider wraps from N_DIV-1 to 0 on an `id_en` edge. `dco_out` rises on that same edge.
- No handshake: `carry` and `borrow` are sampled every edge and must be single-cycle pulses from the filter.

## Test plan
- **Nominal after reset.** Hold reset 4 cycles, then release, with N_DIV=8.
  - During reset: id_out=0, dco_out=0, div_count=0.
  - After release: id_out pulses every 2nd clk; dco_out has period 16 clk, 8 high / 8 low.
- **Single carry** mid-period, one cycle -> exactly one DCO period of 14 clk, then 16 clk periods resume.
- **Single borrow** -> exactly one period of 18 clk, then 16.
- **Simultaneous carry and borrow** in one cycle -> P unchanged, no period deviation.
- **Held inputs**
  - carry held 40 cycles -> id_out high every clk, dco_out period 8.
  - borrow held 40 cycles -> id_out stays 0, div_count constant.
  - Release -> nominal period 16 resumes.
- **Reset mid-operation.** Pending carry with div_count=5, then assert reset -> next edge div_count=0, dco_out=0, id_out=0, and the pending carry is discarded (no insertion after release).
